// File: rtl/wb_regfile_pkg.sv
// Shared CPU definitions used by the write-back stage and register file.
// Holds the register-index constants and the write-back source selection.
package wb_regfile_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_AW-1:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'd0,
    WB_SRC_MEM  = 2'd1,
    WB_SRC_LINK = 2'd2
  } wb_src_e;

  // The link address outranks load data, which outranks the ALU result.
  function automatic wb_src_e wb_src_sel(input logic jal_to_reg, input logic mem_to_reg);
    if (jal_to_reg)      return WB_SRC_LINK;
    else if (mem_to_reg) return WB_SRC_MEM;
    else                 return WB_SRC_ALU;
  endfunction

endpackage

// File: rtl/wb_regfile_reg_array.sv
// Architectural register storage: one synchronous write port, two
// asynchronous read ports, no bypass and no r0 masking.
module wb_regfile_reg_array
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [NREG];

  // NOTE: the whole array is cleared on reset because software may read a
  // register before writing it; this rules out mapping onto a block RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects value and destination from MEM/WB, commits to
// the register array, serves decode reads with write-through bypass.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_reg_write,
  input  logic              wb_mem_to_reg,
  input  logic              wb_r31_to_reg,
  input  logic              wb_jal_to_reg,
  input  logic [DATA_W-1:0] wb_alu,
  input  logic [DATA_W-1:0] wb_mem_data,
  input  logic [DATA_W-1:0] wb_link,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_waddr,
  output logic              wb_we,
  output logic [CNT_W-1:0]  commit_cnt
);

  wb_src_e           wb_src;
  logic [DATA_W-1:0] arr_rs_data;
  logic [DATA_W-1:0] arr_rt_data;
  logic [CNT_W-1:0]  commit_cnt_q;
  logic [CNT_W-1:0]  commit_cnt_d;

  assign wb_src   = wb_src_sel(wb_jal_to_reg, wb_mem_to_reg);
  assign wb_waddr = wb_r31_to_reg ? REG_RA : wb_dest;
  assign wb_we    = wb_reg_write && (wb_waddr != REG_ZERO);

  // NOTE: every output of a combinational block gets a default first so a
  // missed case arm cannot infer a latch.
  always_comb begin
    wb_data = wb_alu;
    unique case (wb_src)
      WB_SRC_LINK: wb_data = wb_link;
      WB_SRC_MEM:  wb_data = wb_mem_data;
      default:     wb_data = wb_alu;
    endcase
  end

  wb_regfile_reg_array #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_reg_array (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb_we),
    .waddr_i   (wb_waddr),
    .wdata_i   (wb_data),
    .raddr_a_i (rs_addr),
    .raddr_b_i (rt_addr),
    .rdata_a_o (arr_rs_data),
    .rdata_b_o (arr_rt_data)
  );

  // r0 is hard-wired to zero; a same-cycle commit to the read index bypasses.
  always_comb begin
    rs_data = arr_rs_data;
    if (rs_addr == REG_ZERO)                rs_data = '0;
    else if (wb_we && (rs_addr == wb_waddr)) rs_data = wb_data;
  end

  always_comb begin
    rt_data = arr_rt_data;
    if (rt_addr == REG_ZERO)                rt_data = '0;
    else if (wb_we && (rt_addr == wb_waddr)) rt_data = wb_data;
  end

  // Counter wraps modulo 2^CNT_W with no overflow indication.
  always_comb begin
    commit_cnt_d = commit_cnt_q;
    if (wb_we) commit_cnt_d = commit_cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) commit_cnt_q <= '0;
    else     commit_cnt_q <= commit_cnt_d;
  end

  assign commit_cnt = commit_cnt_q;

endmodule
